// File: rtl/pwm_pkg.sv
// Shared direction type and channel-index sizing for the multi-channel PWM generator.
// Pure declarations: no latency or flow control of its own.
package pwm_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // Width of a channel index; a single-channel build still gets a 1-bit index.
    function automatic int ch_idx_w(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: tick is combinational, high once every presc+1 clk cycles while enabled.
// No flow control; enable low parks the count at zero so the first enabled cycle can tick.
module pwm_prescaler #(
    parameter int PRESC_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [PRESC_LEN-1:0] presc,
    output logic                 tick
);

    localparam logic [PRESC_LEN-1:0] ONE = PRESC_LEN'(1);

    logic [PRESC_LEN-1:0] presc_cnt;

    assign tick = enable && (presc_cnt == presc);

    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + ONE;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: shared prescaled counter driving CHANNELS double-buffered comparators; pwm_pin lags cnt by 1 clk.
// Center-aligned counting exists only when PWM_CENTER_EN is defined; no backpressure, writes always accepted.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CNTR_LEN  = 8,
    parameter int CHANNELS  = 4,
    parameter int PRESC_LEN = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [CNTR_LEN-1:0]             period,
    input  logic [PRESC_LEN-1:0]            presc,
    input  logic                            center_mode,
    input  logic [CHANNELS-1:0]             polarity,
    input  logic                            wr_en,
    input  logic [ch_idx_w(CHANNELS)-1:0]   wr_ch,
    input  logic [CNTR_LEN-1:0]             wr_compare,
    output logic [CHANNELS-1:0]             pwm_pin,
    output logic                            period_tick
);

    localparam logic [CNTR_LEN-1:0] ONE = CNTR_LEN'(1);

    logic [CNTR_LEN-1:0]  cnt;
    logic [CNTR_LEN-1:0]  cnt_nxt;
    logic [CNTR_LEN-1:0]  act_period;
    logic [PRESC_LEN-1:0] act_presc;
    logic                 tick;
    logic                 boundary;
    logic                 load;
    logic [CHANNELS-1:0]  pwm_d;

    pwm_prescaler #(
        .PRESC_LEN (PRESC_LEN)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .presc  (act_presc),
        .tick   (tick)
    );

    // While idle every cycle acts as a boundary, so the first enabled compare already sees the shadows.
    assign load = !enable || boundary;

`ifdef PWM_CENTER_EN
    dir_t dir;
    dir_t dir_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir <= UP;
        end else begin
            dir <= dir_nxt;
        end
    end
`else
    logic unused_center;
    assign unused_center = center_mode;
`endif

    always_comb begin
        cnt_nxt  = cnt;
        boundary = 1'b0;
`ifdef PWM_CENTER_EN
        dir_nxt  = dir;
`endif
        if (!enable) begin
            cnt_nxt = '0;
`ifdef PWM_CENTER_EN
            dir_nxt = UP;
        end else if (tick && center_mode) begin
            if (act_period == '0) begin
                boundary = 1'b1;
                cnt_nxt  = '0;
                dir_nxt  = UP;
            end else if (dir == UP) begin
                if (cnt == act_period) begin
                    dir_nxt = DOWN;
                    cnt_nxt = cnt - ONE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end else if (cnt == '0) begin
                boundary = 1'b1;
                dir_nxt  = UP;
                cnt_nxt  = ONE;
            end else begin
                cnt_nxt = cnt - ONE;
            end
`endif
        end else if (tick) begin
`ifdef PWM_CENTER_EN
            dir_nxt = UP;
`endif
            if (cnt == act_period) begin
                boundary = 1'b1;
                cnt_nxt  = '0;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            act_period  <= '0;
            act_presc   <= '0;
            pwm_pin     <= '0;
            period_tick <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (load) begin
                act_period <= period;
                act_presc  <= presc;
            end
            pwm_pin     <= pwm_d;
            period_tick <= boundary;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNTR_LEN-1:0] shadow_cmp;
        logic [CNTR_LEN-1:0] active_cmp;
        logic                wr_hit;

        // Out-of-range indices never match any channel, so such writes fall away.
        assign wr_hit = wr_en && (32'(wr_ch) == i);

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_cmp <= '0;
                active_cmp <= '0;
            end else begin
                if (wr_hit) begin
                    shadow_cmp <= wr_compare;
                end
                if (load) begin
                    active_cmp <= wr_hit ? wr_compare : shadow_cmp;
                end
            end
        end

        assign pwm_d[i] = enable ? ((active_cmp > cnt) ^ polarity[i]) : polarity[i];
    end

endmodule
